// File: rtl/spi_sram_emu.sv
// SPI serial SRAM emulator (23LC1024-style) with byte/page/sequential modes.
// Optional quad I/O (EQIO/RSTIO commands) is built when SPI_SRAM_EMU_QUAD_EN is defined.
module spi_sram_emu #(
    parameter int ADDR_WIDTH = 17,
    parameter int PAGE_BYTES = 32,
    parameter     INIT_FILE  = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic [1:0] mode
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, RD, WR, MODE_RD, MODE_WR, IGNORE
    } state_t;

    localparam int                    MEM_BYTES = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_BYTES - 1);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    state_t state, state_nxt;

    logic [1:0] sck_sync, cs_sync;
    logic [3:0] sio_meta, sio_s;
    logic       sck_s, cs_s, sck_d;
    logic       sck_rise, sck_fall;

    logic [4:0]            bit_cnt, cnt_nxt, target, step;
    logic [6:0]            sh;
    logic [7:0]            byte_nxt, src_byte, obyte, rd_data;
    logic [ADDR_WIDTH-1:0] addr, addr_shift, addr_adv;
    logic [2:0]            rd_cnt;
    logic                  rd_done, is_read, last_beat, collect_done, wr_en;
    logic [3:0]            out_q;
    logic                  quad;

    // Idle values (cs_n high, sck low) keep a reset from producing a phantom edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= 2'b00;
            cs_sync  <= 2'b11;
            sio_meta <= 4'h0;
            sio_s    <= 4'h0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            cs_sync  <= {cs_sync[0], cs_n};
            sio_meta <= sio_in;
            sio_s    <= sio_meta;
            sck_d    <= sck_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign sck_rise = sck_s & ~sck_d & ~cs_s;
    assign sck_fall = ~sck_s & sck_d & ~cs_s;

`ifdef SPI_SRAM_EMU_QUAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            quad <= 1'b0;
        else if (state == CMD && collect_done) begin
            if (byte_nxt == 8'h38)
                quad <= 1'b1;
            else if (byte_nxt == 8'hFF)
                quad <= 1'b0;
        end
    end
`else
    assign quad = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        step         = quad ? 5'd4 : 5'd1;
        cnt_nxt      = bit_cnt + step;
        target       = (state == ADDR) ? 5'd24 : 5'd8;
        collect_done = sck_rise && (cnt_nxt == target);
        byte_nxt     = quad ? {sh[3:0], sio_s} : {sh, sio_s[0]};
        addr_shift   = quad ? {addr[ADDR_WIDTH-5:0], sio_s} : {addr[ADDR_WIDTH-2:0], sio_s[0]};
        src_byte     = (state == MODE_RD) ? {mode, 6'b0} : rd_data;
        last_beat    = rd_cnt == (quad ? 3'd1 : 3'd7);
        wr_en        = (state == WR) && collect_done;
        case (mode)
            MODE_PAGE: addr_adv = (addr & ~PAGE_MASK) | ((addr + ADDR_WIDTH'(1)) & PAGE_MASK);
            default:   addr_adv = addr + ADDR_WIDTH'(1);
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: if (collect_done) begin
                    case (byte_nxt)
                        CMD_READ, CMD_WRITE: state_nxt = ADDR;
                        CMD_RDMR:            state_nxt = MODE_RD;
                        CMD_WRMR:            state_nxt = MODE_WR;
                        default:             state_nxt = IGNORE;
                    endcase
                end
                ADDR:    if (collect_done) state_nxt = is_read ? (quad ? DUMMY : RD) : WR;
                DUMMY:   if (collect_done) state_nxt = RD;
                RD:      if (sck_fall && rd_cnt == 3'd0 && rd_done) state_nxt = IGNORE;
                WR:      if (collect_done && mode == MODE_BYTE) state_nxt = IGNORE;
                MODE_WR: if (collect_done) state_nxt = IGNORE;
                default: state_nxt = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            sh      <= '0;
            addr    <= '0;
            rd_cnt  <= '0;
            rd_done <= 1'b0;
            is_read <= 1'b0;
            obyte   <= '0;
            out_q   <= '0;
            mode    <= MODE_SEQ;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            rd_cnt  <= '0;
            rd_done <= 1'b0;
            out_q   <= '0;
        end else if (sck_rise) begin
            if (state inside {CMD, ADDR, DUMMY, WR, MODE_WR}) begin
                sh      <= byte_nxt[6:0];
                bit_cnt <= collect_done ? 5'd0 : cnt_nxt;
            end
            if (state == ADDR)
                addr <= addr_shift;
            if (state == CMD && collect_done)
                is_read <= (byte_nxt == CMD_READ);
            if (state == WR && collect_done)
                addr <= addr_adv;
            if (state == MODE_WR && collect_done && byte_nxt[7:6] != 2'b11)
                mode <= byte_nxt[7:6];
        end else if (sck_fall && (state == RD || state == MODE_RD)) begin
            // First beat of a byte comes straight from the source; later beats from the shifter.
            if (rd_cnt == 3'd0) begin
                out_q <= quad ? src_byte[7:4] : {2'b00, src_byte[7], 1'b0};
                obyte <= quad ? {src_byte[3:0], 4'h0} : {src_byte[6:0], 1'b0};
            end else begin
                out_q <= quad ? obyte[7:4] : {2'b00, obyte[7], 1'b0};
                obyte <= quad ? {obyte[3:0], 4'h0} : {obyte[6:0], 1'b0};
            end
            if (last_beat) begin
                rd_cnt <= 3'd0;
                if (state == RD) begin
                    addr    <= addr_adv;
                    rd_done <= (mode == MODE_BYTE);
                end
            end else begin
                rd_cnt <= rd_cnt + 3'd1;
            end
        end
    end

    logic [7:0] mem [MEM_BYTES];

    // NOTE: the array has no reset so its contents survive a reset pulse and map to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= byte_nxt;
        rd_data <= mem[addr];
    end

    assign sio_out = out_q;
    assign sio_oe  = (state == RD || state == MODE_RD) ? (quad ? 4'hF : 4'b0010) : 4'h0;

endmodule

// File: tb/tb_spi_sram_emu.sv
// Scoreboard bench for spi_sram_emu: an SPI master drives transactions, a byte model
// predicts read data, and each test compares the popped expectations with what came back.
module tb_spi_sram_emu;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck;
    logic       cs_n;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic [3:0] sio_oe;
    logic [1:0] mode;

    spi_sram_emu dut (
        .clk    (clk),
        .reset  (reset),
        .sck    (sck),
        .cs_n   (cs_n),
        .sio_in (sio_in),
        .sio_out(sio_out),
        .sio_oe (sio_oe),
        .mode   (mode)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model [logic [16:0]];
    logic [1:0] cur_mode = 2'b01;
    bit         tb_quad  = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    logic [7:0] wbuf  [8];
    logic [3:0] oe_any, oe_all, stray;

    function automatic logic [16:0] nxt(input logic [16:0] a);
        if (cur_mode == 2'b10)
            return {a[16:5], a[4:0] + 5'd1};
        return a + 17'd1;
    endfunction

    task automatic beat(input logic [3:0] d, output logic [3:0] s);
        sio_in = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        s = sio_out;
        oe_any |= sio_oe;
        oe_all &= sio_oe;
        if (!tb_quad) stray |= sio_out & 4'b1101;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] s;
        rx = 8'h00;
        if (tb_quad) begin
            for (int i = 1; i >= 0; i--) begin
                beat(tx[i*4 +: 4], s);
                rx = {rx[3:0], s};
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                beat({3'b000, tx[i]}, s);
                rx = {rx[6:0], s[1]};
            end
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [16:0] a);
        logic [7:0] rx;
        xfer(cmd, rx);
        xfer({7'b0, a[16]}, rx);
        xfer(a[15:8], rx);
        xfer(a[7:0], rx);
    endtask

    task automatic do_write(input logic [16:0] a, input int n);
        logic [7:0]  rx;
        logic [16:0] wa = a;
        cs_low();
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            xfer(wbuf[i], rx);
            if (!(cur_mode == 2'b00 && i > 0)) begin
                model[wa] = wbuf[i];
                wa = nxt(wa);
            end
        end
        cs_high();
    endtask

    task automatic do_read(input logic [16:0] a, input int n);
        logic [7:0]  rx;
        logic [16:0] ra = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model[ra]);
            ra = nxt(ra);
        end
        cs_low();
        send_hdr(8'h03, a);
        if (tb_quad) xfer(8'h00, rx);
        oe_any = 4'h0;
        oe_all = 4'hF;
        stray  = 4'h0;
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rx);
            rx_q.push_back(rx);
        end
        cs_high();
    endtask

    task automatic wrmr(input logic [7:0] v);
        logic [7:0] rx;
        cs_low();
        xfer(8'h01, rx);
        xfer(v, rx);
        cs_high();
        if (v[7:6] != 2'b11) cur_mode = v[7:6];
    endtask

    task automatic test_reset();
        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; sio_in = 4'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (sio_oe !== 4'h0)  begin n_fail++; $display("FAIL reset_oe: got %h expected 0", sio_oe); end
        n_checks++; if (sio_out !== 4'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", sio_out); end
        n_checks++; if (mode !== 2'b01)   begin n_fail++; $display("FAIL reset_mode: got %b expected 01", mode); end
        reset = 1'b0;
        cur_mode = 2'b01;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] e, g;
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(17'h00010, 2);
        do_read(17'h00010, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL basic_rd: got %h expected %h", g, e); end
        end
        n_checks++;
        if ({oe_any, oe_all} !== 8'h22) begin n_fail++; $display("FAIL basic_oe: got %h/%h expected 2/2", oe_any, oe_all); end
        n_checks++;
        if (stray !== 4'h0) begin n_fail++; $display("FAIL basic_unused_lines: got %h expected 0", stray); end
    endtask

    task automatic test_seq_wrap();
        logic [7:0] e, g;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(17'h1FFFF, 2);
        do_read(17'h1FFFF, 1);
        do_read(17'h00000, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL seq_wrap: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_page();
        logic [7:0] e, g, r1, r2;
        wbuf[0] = 8'h5A;
        do_write(17'h00020, 1);
        wrmr(8'h80);
        n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL page_mode: got %b expected 10", mode); end
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        do_write(17'h0001F, 2);
        do_read(17'h0001F, 2);
        do_read(17'h00000, 1);
        do_read(17'h00020, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL page_wrap: got %h expected %h", g, e); end
        end
        cs_low();
        xfer(8'h05, r1); xfer(8'h00, r1); xfer(8'h00, r2);
        cs_high();
        n_checks++; if (r1 !== 8'h80) begin n_fail++; $display("FAIL rdmr_1: got %h expected 80", r1); end
        n_checks++; if (r2 !== 8'h80) begin n_fail++; $display("FAIL rdmr_2: got %h expected 80", r2); end
        wrmr(8'hC0);
        n_checks++; if (mode !== 2'b10) begin n_fail++; $display("FAIL wrmr_11_ignored: got %b expected 10", mode); end
    endtask

    task automatic test_byte_mode();
        logic [7:0] e, g, rx;
        wbuf[0] = 8'h9C;
        do_write(17'h00005, 1);
        wrmr(8'h00);
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL byte_mode: got %b expected 00", mode); end
        exp_q.push_back(model[17'h00005]);
        cs_low();
        send_hdr(8'h03, 17'h00005);
        oe_any = 4'h0; oe_all = 4'hF;
        xfer(8'h00, rx);
        rx_q.push_back(rx);
        n_checks++;
        if ({oe_any, oe_all} !== 8'h22) begin n_fail++; $display("FAIL byte_first_oe: got %h/%h expected 2/2", oe_any, oe_all); end
        oe_any = 4'h0;
        xfer(8'h00, rx);
        xfer(8'h00, rx);
        cs_high();
        n_checks++; if (oe_any !== 4'h0) begin n_fail++; $display("FAIL byte_rest_oe: got %h expected 0", oe_any); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL byte_rd: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] e, g;
        logic [3:0] s;
        wrmr(8'h40);
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL seq_restore: got %b expected 01", mode); end
        wbuf[0] = 8'h77;
        do_write(17'h00040, 1);
        cs_low();
        send_hdr(8'h02, 17'h00040);
        for (int i = 0; i < 4; i++) beat(4'h1, s);
        cs_high();
        do_read(17'h00040, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL partial_discard: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] e, g;
        logic [3:0] s;
        wrmr(8'h80);
        cs_low();
        send_hdr(8'h03, 17'h00010);
        for (int i = 0; i < 3; i++) beat(4'h0, s);
        n_checks++; if (sio_oe !== 4'b0010) begin n_fail++; $display("FAIL mid_read_oe: got %h expected 2", sio_oe); end
        reset = 1'b1;
        #1;
        n_checks++; if (sio_oe !== 4'h0) begin n_fail++; $display("FAIL reset_oe_async: got %h expected 0", sio_oe); end
        n_checks++; if (mode !== 2'b01)  begin n_fail++; $display("FAIL reset_mode_async: got %b expected 01", mode); end
        cur_mode = 2'b01;
        cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        do_read(17'h00010, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL array_kept: got %h expected %h", g, e); end
        end
    endtask

`ifdef SPI_SRAM_EMU_QUAD_EN
    task automatic test_quad();
        logic [7:0] e, g, rx;
        cs_low(); xfer(8'h38, rx); cs_high();
        tb_quad = 1'b1;
        do_read(17'h00010, 2);
        n_checks++;
        if ({oe_any, oe_all} !== 8'hFF) begin n_fail++; $display("FAIL quad_oe: got %h/%h expected F/F", oe_any, oe_all); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL quad_rd: got %h expected %h", g, e); end
        end
        cs_low(); xfer(8'hFF, rx); cs_high();
        tb_quad = 1'b0;
        cs_low();
        xfer(8'h05, rx);
        oe_any = 4'h0; oe_all = 4'hF;
        xfer(8'h00, rx);
        cs_high();
        n_checks++; if (rx !== {cur_mode, 6'b0}) begin n_fail++; $display("FAIL rstio_rdmr: got %h expected %h", rx, {cur_mode, 6'b0}); end
        n_checks++;
        if ({oe_any, oe_all} !== 8'h22) begin n_fail++; $display("FAIL rstio_oe: got %h/%h expected 2/2", oe_any, oe_all); end
    endtask
`else
    task automatic test_cmd_ignore();
        logic [7:0] rx;
        cs_low();
        xfer(8'h38, rx);
        oe_any = 4'h0;
        xfer(8'h00, rx); xfer(8'h00, rx);
        cs_high();
        n_checks++; if (oe_any !== 4'h0) begin n_fail++; $display("FAIL eqio_ignored: got %h expected 0", oe_any); end
        cs_low();
        xfer(8'hFF, rx);
        oe_any = 4'h0;
        xfer(8'h00, rx);
        cs_high();
        n_checks++; if (oe_any !== 4'h0) begin n_fail++; $display("FAIL rstio_ignored: got %h expected 0", oe_any); end
        cs_low();
        xfer(8'h05, rx); xfer(8'h00, rx);
        cs_high();
        n_checks++; if (rx !== {cur_mode, 6'b0}) begin n_fail++; $display("FAIL spi_after_eqio: got %h expected %h", rx, {cur_mode, 6'b0}); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0]  e, g;
        logic [16:0] a;
        for (int r = 0; r < 2; r++) begin
            a = 17'($urandom);
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            do_write(a, 8);
            do_read(a, 8);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); g = rx_q.pop_front(); n_checks++;
                if (g !== e) begin n_fail++; $display("FAIL b2b_rd @%h: got %h expected %h", a, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq_wrap();
        test_page();
        test_byte_mode();
        test_abort();
        test_reset_mid_read();
`ifdef SPI_SRAM_EMU_QUAD_EN
        test_quad();
`else
        test_cmd_ignore();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
